itch_stream_parser: RTL and testbench
=====================================

Name: itch_stream_parser

Overview:
Parametrised next-generation ITCH parser. It sits between header_skip and strategy, and consumes the UDP payload byte stream as MoldUDP64 framing: a session header, then N length-prefixed ITCH messages per packet. It extracts every Add Order message in a bundle, not just one fixed message per packet, and outputs each as a decoded record with valid/ready backpressure. Truncated or malformed framing is detected and flagged.

Parameters:
MOLD_HDR_LEN, 20, bytes of MoldUDP64 header skipped at the start of each packet (0 = no header)
ADD_TYPE, 8'h41, message type byte selecting Add Order ('A')
ADD_MIN_LEN, 36, minimum message length for an Add Order to be decoded
QTY_W, 16, output quantity width (1..32); shares saturate to this width
PRICE_W, 32, output price width (1..32); low PRICE_W bits of price are kept

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
s_axis_tdata  in  8  payload byte
s_axis_tvalid  in  1  byte valid
s_axis_tready  out  1  byte accepted when valid&ready
s_axis_tlast  in  1  last byte of packet
m_order_id  out  64  order reference number
m_stock_locate  out  16  stock locate code
m_side  out  1  1 = buy ('B'), 0 = any other side byte
m_qty  out  QTY_W  saturated shares
m_price  out  PRICE_W  price
m_valid  out  1  record valid; held until m_ready
m_ready  in  1  downstream accept
err_pulse  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset values: all m_* = 0, m_valid = 0, err_pulse = 0, state = HDR, counters = 0. Reset mid-packet discards the remainder; the next accepted byte is treated as packet start.
- s_axis_tready = !m_valid || m_ready. This is combinational, and it is the only backpressure source.
- All state advances only on an accepted byte (tvalid & tready).
- State HDR:
  - Count MOLD_HDR_LEN bytes, then go to LEN_HI.
  - tlast inside the header -> err_pulse, stay HDR.
  - If MOLD_HDR_LEN = 0, HDR is bypassed and the start state is LEN_HI.
- State LEN_HI: latch the length MSB, go to LEN_LO. tlast here -> err_pulse, go HDR.
- State LEN_LO: latch the length LSB.
  - len = 0: go LEN_HI. If tlast is also set, go HDR with no error.
  - tlast with len > 0: err_pulse, go HDR.
  - Otherwise go BODY with idx = 0.
- State BODY: idx counts 0..len-1 (16-bit).
  - idx 0 = type byte. Set capture flag = (type == ADD_TYPE) && (len >= ADD_MIN_LEN).
  - Big-endian field offsets: locate 1-2, order ref 11-18, side 19, shares 20-23, price 32-35.
  - Bytes beyond offset 35 are ignored. Non-Add messages are consumed and discarded.
- Message end (idx == len-1 accepted):
  - If capture is set, load the output register; m_valid = 1 on the next cycle. Latency is 1 clk from the last message byte.
  - tlast on the same byte -> HDR. No tlast -> LEN_HI.
- tlast with idx < len-1: err_pulse, partial message dropped (no m_valid), go HDR.
- Quantity: shares > 2^QTY_W-1 -> m_qty = all ones; otherwise shares[QTY_W-1:0].
- Output register: a new load and m_ready in the same cycle replaces the record, and m_valid stays 1. m_valid clears only on m_ready without a load. Output fields are stable while m_valid & !m_ready.
- Back-to-back messages: a new message's final byte cannot be accepted while the previous record is unaccepted, so no record is ever lost.

Optional Feature:
PARSER_STATS_EN:
- Defined: adds output ports stat_msgs[31:0] (messages completed), stat_adds[31:0] (Add records loaded) and stat_errs[31:0] (err_pulse count). All are wrapping counters, cleared by rst.
- Undefined: the ports and counters are absent. Parsing behaviour is identical either way.

Test Plan:
1. One packet: 20-byte header, len = 36, 'A' with order ref 0x0102030405060708, locate 0x0007, side 'B', shares 100, price 10000, tlast on the final byte -> one m_valid with those fields, m_side = 1, m_qty = 100, m_price = 10000; err_pulse never asserted.
2. Bundle of 3 messages ('A' len 36, 'D' len 19, 'A' len 40 with side 'S', order ref 0xAA, shares 70000) with m_ready tied 1 -> exactly two records; the second has m_side = 0 and m_qty = 16'hFFFF (saturated).
3. Same bundle with m_ready held 0 for 50 cycles after the first record -> s_axis_tready low, first record stable, no loss; both records delivered after release.
4. tlast at BODY idx 20 of an 'A' with len 36 -> err_pulse exactly 1 cycle, no m_valid; the next well-formed packet decodes correctly.
5. len = 0 entry followed by a valid 'A', and an 'A' with len 30 -> len 0 skipped silently; len 30 message consumed with no record; valid 'A' decoded.
6. rst asserted mid-BODY, then a fresh packet -> outputs zero during reset; fresh packet decoded correctly. With PARSER_STATS_EN defined, scenario 2 gives stat_msgs = 3, stat_adds = 2, stat_errs = 0.

Source files
------------

// File: rtl/itch_stream_parser.sv
// MoldUDP64 / ITCH stream parser: walks length-prefixed messages in each packet
// and emits every Add Order as a decoded record. Optional stats: PARSER_STATS_EN.
module itch_stream_parser #(
  parameter int          MOLD_HDR_LEN = 20,
  parameter logic [7:0]  ADD_TYPE     = 8'h41,
  parameter int          ADD_MIN_LEN  = 36,
  parameter int          QTY_W        = 16,
  parameter int          PRICE_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  output logic [63:0]        m_order_id,
  output logic [15:0]        m_stock_locate,
  output logic               m_side,
  output logic [QTY_W-1:0]   m_qty,
  output logic [PRICE_W-1:0] m_price,
  output logic               m_valid,
  input  logic               m_ready,
`ifdef PARSER_STATS_EN
  output logic [31:0]        stat_msgs,
  output logic [31:0]        stat_adds,
  output logic [31:0]        stat_errs,
`endif
  output logic               err_pulse
);

  typedef enum logic [1:0] {S_HDR, S_LEN_HI, S_LEN_LO, S_BODY} state_t;

  localparam state_t      START    = (MOLD_HDR_LEN == 0) ? S_LEN_HI : S_HDR;
  localparam logic [15:0] HDR_LAST = 16'(MOLD_HDR_LEN - 1);
  localparam logic [15:0] MIN_LEN  = 16'(ADD_MIN_LEN);
  localparam logic [32:0] QTY_MAX  = (33'd1 << QTY_W) - 33'd1;

  state_t               state_q;
  logic [15:0]          hdr_cnt_q;
  logic [7:0]           len_hi_q;
  logic [15:0]          len_q;
  logic [15:0]          idx_q;
  logic                 cap_q;
  logic [15:0]          locate_q;
  logic [63:0]          oref_q;
  logic                 side_q;
  logic [31:0]          shares_q;
  logic [31:0]          price_q;

  logic [63:0]          m_oref_q;
  logic [15:0]          m_locate_q;
  logic                 m_side_q;
  logic [QTY_W-1:0]     m_qty_q;
  logic [PRICE_W-1:0]   m_price_q;
  logic                 m_valid_q;
  logic                 err_q;

  logic                 acc;
  logic [15:0]          len_d;
  logic                 msg_last;
  logic                 cap_d;
  logic [15:0]          locate_d;
  logic [63:0]          oref_d;
  logic                 side_d;
  logic [31:0]          shares_d;
  logic [31:0]          price_d;
  logic [QTY_W-1:0]     qty_d;
  logic                 err_set;
  logic                 msg_done;
  logic                 load;

  assign s_axis_tready = !m_valid_q || m_ready;
  assign acc           = s_axis_tvalid && s_axis_tready;
  assign len_d         = {len_hi_q, s_axis_tdata};
  assign msg_last      = (idx_q == len_q - 16'd1);

  // Field capture sees the byte in flight so the final byte can feed the load directly.
  always_comb begin
    cap_d    = cap_q;
    locate_d = locate_q;
    oref_d   = oref_q;
    side_d   = side_q;
    shares_d = shares_q;
    price_d  = price_q;
    if (idx_q == 16'd0)
      cap_d = (s_axis_tdata == ADD_TYPE) && (len_q >= MIN_LEN);
    if (idx_q == 16'd1 || idx_q == 16'd2)
      locate_d = {locate_q[7:0], s_axis_tdata};
    if (idx_q >= 16'd11 && idx_q <= 16'd18)
      oref_d = {oref_q[55:0], s_axis_tdata};
    if (idx_q == 16'd19)
      side_d = (s_axis_tdata == 8'h42);
    if (idx_q >= 16'd20 && idx_q <= 16'd23)
      shares_d = {shares_q[23:0], s_axis_tdata};
    if (idx_q >= 16'd32 && idx_q <= 16'd35)
      price_d = {price_q[23:0], s_axis_tdata};
  end

  always_comb begin
    qty_d = shares_d[QTY_W-1:0];
    if ({1'b0, shares_d} > QTY_MAX)
      qty_d = '1;
  end

  always_comb begin
    err_set = 1'b0;
    if (acc && s_axis_tlast) begin
      case (state_q)
        S_HDR:    err_set = 1'b1;
        S_LEN_HI: err_set = 1'b1;
        S_LEN_LO: err_set = (len_d != 16'd0);
        S_BODY:   err_set = !msg_last;
        default:  err_set = 1'b0;
      endcase
    end
  end

  assign msg_done = acc && (state_q == S_BODY) && msg_last;
  assign load     = msg_done && cap_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= START;
      hdr_cnt_q  <= '0;
      len_hi_q   <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      cap_q      <= 1'b0;
      locate_q   <= '0;
      oref_q     <= '0;
      side_q     <= 1'b0;
      shares_q   <= '0;
      price_q    <= '0;
      m_oref_q   <= '0;
      m_locate_q <= '0;
      m_side_q   <= 1'b0;
      m_qty_q    <= '0;
      m_price_q  <= '0;
      m_valid_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_set;
      if (m_valid_q && m_ready)
        m_valid_q <= 1'b0;
      if (acc) begin
        case (state_q)
          S_HDR: begin
            if (s_axis_tlast) begin
              hdr_cnt_q <= '0;
            end else if (hdr_cnt_q == HDR_LAST) begin
              hdr_cnt_q <= '0;
              state_q   <= S_LEN_HI;
            end else begin
              hdr_cnt_q <= hdr_cnt_q + 16'd1;
            end
          end
          S_LEN_HI: begin
            len_hi_q <= s_axis_tdata;
            state_q  <= s_axis_tlast ? START : S_LEN_LO;
          end
          S_LEN_LO: begin
            len_q <= len_d;
            idx_q <= '0;
            if (len_d == 16'd0)
              state_q <= s_axis_tlast ? START : S_LEN_HI;
            else
              state_q <= s_axis_tlast ? START : S_BODY;
          end
          S_BODY: begin
            cap_q    <= cap_d;
            locate_q <= locate_d;
            oref_q   <= oref_d;
            side_q   <= side_d;
            shares_q <= shares_d;
            price_q  <= price_d;
            idx_q    <= idx_q + 16'd1;
            if (msg_last)
              state_q <= s_axis_tlast ? START : S_LEN_HI;
            else if (s_axis_tlast)
              state_q <= START;
          end
          default: state_q <= START;
        endcase
      end
      // A load wins over a same-cycle accept so the new record stays valid.
      if (load) begin
        m_oref_q   <= oref_d;
        m_locate_q <= locate_d;
        m_side_q   <= side_d;
        m_qty_q    <= qty_d;
        m_price_q  <= price_d[PRICE_W-1:0];
        m_valid_q  <= 1'b1;
      end
    end
  end

`ifdef PARSER_STATS_EN
  logic [31:0] stat_msgs_q;
  logic [31:0] stat_adds_q;
  logic [31:0] stat_errs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_msgs_q <= '0;
      stat_adds_q <= '0;
      stat_errs_q <= '0;
    end else begin
      if (msg_done) stat_msgs_q <= stat_msgs_q + 32'd1;
      if (load)     stat_adds_q <= stat_adds_q + 32'd1;
      if (err_set)  stat_errs_q <= stat_errs_q + 32'd1;
    end
  end

  assign stat_msgs = stat_msgs_q;
  assign stat_adds = stat_adds_q;
  assign stat_errs = stat_errs_q;
`endif

  assign m_order_id     = m_oref_q;
  assign m_stock_locate = m_locate_q;
  assign m_side         = m_side_q;
  assign m_qty          = m_qty_q;
  assign m_price        = m_price_q;
  assign m_valid        = m_valid_q;
  assign err_pulse      = err_q;

endmodule

// File: tb/tb_itch_stream_parser.sv
// Scoreboard bench for itch_stream_parser: directed packets push expected records,
// a negedge monitor pops and compares on every output handshake.
module tb_itch_stream_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [63:0] m_order_id;
  logic [15:0] m_stock_locate;
  logic        m_side;
  logic [15:0] m_qty;
  logic [31:0] m_price;
  logic        m_valid;
  logic        m_ready;
  logic        err_pulse;
`ifdef PARSER_STATS_EN
  logic [31:0] stat_msgs, stat_adds, stat_errs;
`endif

  always #5 clk = ~clk;

  itch_stream_parser dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .m_order_id     (m_order_id),
    .m_stock_locate (m_stock_locate),
    .m_side         (m_side),
    .m_qty          (m_qty),
    .m_price        (m_price),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
`ifdef PARSER_STATS_EN
    .stat_msgs      (stat_msgs),
    .stat_adds      (stat_adds),
    .stat_errs      (stat_errs),
`endif
    .err_pulse      (err_pulse)
  );

  typedef struct packed {
    logic [63:0] oref;
    logic [15:0] loc;
    logic        side;
    logic [15:0] qty;
    logic [31:0] price;
  } rec_t;

  rec_t        exp_q[$];
  logic [7:0]  pkt[$];
  int          total = 0;
  int          bad = 0;
  int          err_seen = 0;
  logic        hold_valid = 1'b0;
  logic [63:0] hold_oref;
  logic [64:0] hold_rest;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      hold_valid = 1'b0;
    end else begin
      if (err_pulse) err_seen++;
      if (m_valid && !m_ready && hold_valid) begin
        check("hold_oref", m_order_id, hold_oref);
        check("hold_fields", {m_stock_locate, m_side, m_qty, m_price}, hold_rest);
      end
      hold_valid = m_valid && !m_ready;
      hold_oref  = m_order_id;
      hold_rest  = {m_stock_locate, m_side, m_qty, m_price};
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_record", m_order_id, 0);
          if (m_order_id == 0) check("unexpected_record_flag", 1, 0);
        end else begin
          rec_t e;
          e = exp_q.pop_front();
          check("rec_oref", m_order_id, e.oref);
          check("rec_locate", m_stock_locate, e.loc);
          check("rec_side", m_side, e.side);
          check("rec_qty", m_qty, e.qty);
          check("rec_price", m_price, e.price);
        end
      end
    end
  end

  task automatic hdr();
    repeat (20) pkt.push_back(8'h5A);
  endtask

  task automatic msg(input logic [7:0] typ, input logic [15:0] len, input logic [15:0] loc,
                     input logic [63:0] oref, input logic [7:0] side,
                     input logic [31:0] shares, input logic [31:0] price);
    logic [7:0] b;
    pkt.push_back(len[15:8]);
    pkt.push_back(len[7:0]);
    for (int i = 0; i < int'(len); i++) begin
      b = 8'(i) ^ 8'h3C;
      if (i == 0) b = typ;
      else if (i == 1) b = loc[15:8];
      else if (i == 2) b = loc[7:0];
      else if (i >= 11 && i <= 18) b = oref[8*(18-i) +: 8];
      else if (i == 19) b = side;
      else if (i >= 20 && i <= 23) b = shares[8*(23-i) +: 8];
      else if (i >= 32 && i <= 35) b = price[8*(35-i) +: 8];
      pkt.push_back(b);
    end
  endtask

  task automatic expect_rec(input logic [63:0] oref, input logic [15:0] loc, input logic side,
                            input logic [15:0] qty, input logic [31:0] price);
    rec_t e;
    e.oref = oref; e.loc = loc; e.side = side; e.qty = qty; e.price = price;
    exp_q.push_back(e);
  endtask

  // n = 0 sends the whole packet; with_last puts tlast on the final byte sent.
  task automatic send_pkt(input int n, input bit with_last);
    int cnt;
    int guard;
    bit ok;
    cnt = (n > 0) ? n : pkt.size();
    for (int i = 0; i < cnt; i++) begin
      s_axis_tdata  = pkt[i];
      s_axis_tlast  = with_last && (i == cnt - 1);
      s_axis_tvalid = 1'b1;
      guard = 0;
      ok = 1'b0;
      while (!ok && guard < 2000) begin
        @(negedge clk);
        ok = s_axis_tready;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!ok) begin
        check("tready_timeout", 0, 1);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    pkt.delete();
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || m_valid) && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  task automatic bundle();
    hdr();
    msg(8'h41, 16'd36, 16'h1234, 64'h1111, 8'h42, 32'd5, 32'h00ABCDEF);
    msg(8'h44, 16'd19, 16'h0001, 64'h2222, 8'h42, 32'd9, 32'd9);
    msg(8'h41, 16'd40, 16'h0002, 64'hAA, 8'h53, 32'd70000, 32'h12345678);
    expect_rec(64'h1111, 16'h1234, 1'b1, 16'd5, 32'h00ABCDEF);
    expect_rec(64'hAA, 16'h0002, 1'b0, 16'hFFFF, 32'h12345678);
  endtask

  initial begin
    int e0;
    int g;
    int lowcnt;
`ifdef PARSER_STATS_EN
    logic [31:0] sm0, sa0, se0;
`endif
    rst = 1'b1;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", m_valid, 0);
    check("reset_err", err_pulse, 0);
    check("reset_oref", m_order_id, 0);
    rst = 1'b0;
    #1;
    check("reset_tready", s_axis_tready, 1);

    // single Add Order
    e0 = err_seen;
    hdr();
    msg(8'h41, 16'd36, 16'h0007, 64'h0102030405060708, 8'h42, 32'd100, 32'd10000);
    expect_rec(64'h0102030405060708, 16'h0007, 1'b1, 16'd100, 32'd10000);
    send_pkt(0, 1'b1);
    drain("s1_drain");
    check("s1_err", err_seen - e0, 0);

    // three-message bundle, m_ready high
    e0 = err_seen;
`ifdef PARSER_STATS_EN
    sm0 = stat_msgs; sa0 = stat_adds; se0 = stat_errs;
`endif
    bundle();
    send_pkt(0, 1'b1);
    drain("s2_drain");
    check("s2_err", err_seen - e0, 0);
`ifdef PARSER_STATS_EN
    check("s2_stat_msgs", stat_msgs - sm0, 3);
    check("s2_stat_adds", stat_adds - sa0, 2);
    check("s2_stat_errs", stat_errs - se0, 0);
`endif

    // same bundle with a 50-cycle stall after the first record
    e0 = err_seen;
    m_ready = 1'b0;
    bundle();
    fork
      send_pkt(0, 1'b1);
      begin
        g = 0;
        while (!m_valid && g < 2000) begin
          @(negedge clk);
          g++;
        end
        check("s3_first_valid", m_valid, 1);
        lowcnt = 0;
        repeat (50) begin
          @(negedge clk);
          if (!s_axis_tready && m_valid) lowcnt++;
        end
        check("s3_tready_low", lowcnt, 50);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    drain("s3_drain");
    check("s3_err", err_seen - e0, 0);

    // truncated Add at body idx 20, then a good packet
    e0 = err_seen;
    hdr();
    msg(8'h41, 16'd36, 16'h0009, 64'h77, 8'h42, 32'd1, 32'd1);
    send_pkt(43, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("s4_err_cycles", err_seen - e0, 1);
    check("s4_no_valid", m_valid, 0);
    hdr();
    msg(8'h41, 16'd36, 16'h0055, 64'hDEADBEEFCAFEF00D, 8'h42, 32'd1234, 32'h7FFFFFFF);
    expect_rec(64'hDEADBEEFCAFEF00D, 16'h0055, 1'b1, 16'd1234, 32'h7FFFFFFF);
    send_pkt(0, 1'b1);
    drain("s4_drain");
    check("s4_err_total", err_seen - e0, 1);

    // len 0 entry, valid Add, short Add (len 30)
    e0 = err_seen;
    hdr();
    pkt.push_back(8'h00);
    pkt.push_back(8'h00);
    msg(8'h41, 16'd36, 16'h0100, 64'h0000000100000002, 8'h53, 32'd65535, 32'd42);
    msg(8'h41, 16'd30, 16'h0200, 64'h33, 8'h42, 32'd7, 32'd7);
    expect_rec(64'h0000000100000002, 16'h0100, 1'b0, 16'hFFFF, 32'd42);
    send_pkt(0, 1'b1);
    drain("s5_drain");
    check("s5_err", err_seen - e0, 0);

    // reset mid-body, then a fresh packet
    hdr();
    msg(8'h41, 16'd36, 16'h0003, 64'h4444, 8'h42, 32'd3, 32'd3);
    send_pkt(30, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("s6_rst_valid", m_valid, 0);
    check("s6_rst_oref", m_order_id, 0);
    check("s6_rst_fields", {m_stock_locate, m_side, m_qty, m_price}, 0);
    check("s6_rst_err", err_pulse, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    e0 = err_seen;
    hdr();
    msg(8'h41, 16'd36, 16'h0BEE, 64'h0A0B0C0D0E0F1011, 8'h42, 32'd65536, 32'h01020304);
    expect_rec(64'h0A0B0C0D0E0F1011, 16'h0BEE, 1'b1, 16'hFFFF, 32'h01020304);
    send_pkt(0, 1'b1);
    drain("s6_drain");
    check("s6_err", err_seen - e0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
